pseudo_reverse_addr_seq: RTL and testbench
==========================================

Name: pseudo_reverse_addr_seq

Overview:
Command-driven address sequencer for the pseudo-reverse permutation datapath.
- For each accepted command, sweeps a step range and, per step, every natural index v in 0..B^S-1.
- Emits (v, pseudo-reversed z, step) on a valid/ready stream.
- Sits between the NTT/PBS stage controller and the RAM read-address port.
- Owns stage sequencing, back-pressure, abort and error reporting.

Parameters:
S, 4, number of digits (stages); S>=2
B, 2, digit base; power of 2, >=2
B_W, $clog2(B), localparam, digit width
S_W, $clog2(S), localparam, step width
V_W, S*B_W, localparam, index width

Ports:
clk  in  1  clock
a_rst  in  1  asynchronous reset, active-high
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready
cmd_step_first  in  S_W  first step of sweep
cmd_step_last  in  S_W  last step of sweep (inclusive)
abort  in  1  synchronous cancel of current sweep
out_vld  out  1  output valid
out_rdy  in  1  output ready
out_v  out  V_W  natural index v
out_z  out  V_W  pseudo-reverse of v at out_step
out_step  out  S_W  current step
out_sol  out  1  first index of a step (v==0)
out_eol  out  1  last index of a step (v==B^S-1)
out_last  out  1  last beat of the command
done  out  1  1-cycle pulse after last beat accepted
err  out  1  1-cycle pulse on illegal command

Behaviour:
- Reset (a_rst=1, async): FSM=IDLE. Outputs cmd_rdy=0 during reset and 1 in IDLE after reset; all other outputs 0.
- Pseudo-reverse, digit s of z (s in 0..S-1):
  - z[s]=v[s] if s<step;
  - else z[s]=v[S-1-(s-step)].
  - step=0 gives full digit reversal.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_rdy=1. Command accepted on cmd_vld&cmd_rdy.
  - Legal command (first<=last and last<=S-1): load cnt_v=0, cnt_step=first; go to RUN.
  - Illegal command: consumed, err=1 next cycle, stays IDLE, no output beat.
- RUN:
  - cmd_rdy=0, out_vld=1.
  - Beat fields: out_v=cnt_v, out_step=cnt_step, out_z=f(cnt_v,cnt_step).
  - On out_vld&out_rdy: cnt_v increments. At B^S-1, cnt_v wraps to 0 and cnt_step increments.
  - The beat with cnt_v=B^S-1 and cnt_step=last has out_last=1. Its acceptance moves the FSM to DONE.
- DONE: done=1 for one cycle, then IDLE (cmd_rdy=1 next cycle).
- Latency: command accepted in cycle t gives first out_vld in cycle t+1.
- Throughput: 1 beat/cycle while out_rdy=1. Beats per command: (last-first+1)*B^S.
- Stall: while out_vld&!out_rdy, all out_* fields hold stable. out_vld never drops without a handshake, except on abort.
- abort:
  - In RUN: next cycle out_vld=0, FSM=IDLE, no done. A beat accepted in the abort cycle counts as delivered.
  - In IDLE: no effect; abort has priority over cmd_vld in the same cycle (command not accepted, cmd_rdy forced 0).
- Counter widths: cnt_v is V_W bits with explicit wrap compare (no reliance on overflow). cnt_step stops at last, so there is no S_W overflow when S is not a power of 2.
- Reset asserted mid-RUN: immediate return to reset values; in-flight beat lost.

Optional Feature:
PSEUDO_REVERSE_ADDR_SEQ_OUT_REG_EN
- Defined:
  - out_* passes through a 2-entry skid register.
  - First out_vld at t+2; full 1 beat/cycle throughput kept.
  - out_rdy is not combinationally connected to internal counters.
  - done fires after the last beat leaves the skid.
  - abort also flushes the skid.
- Undefined: direct combinational output from counters as above (t+1 latency).

Test Plan:
- S=4,B=2, cmd first=0,last=0, out_rdy=1 -> 16 beats, v=1 gives z=8, v=3 gives z=12, v=15 gives z=15 with out_eol=out_last=1, done pulse one cycle later.
- cmd first=1,last=2 -> 32 beats; step1 v=2 gives z=8; step2 v=4 gives z=8, v=6 gives z=10; out_sol at beats 0 and 16.
- Random out_rdy toggling (50%) on first=0,last=3 -> 64 beats exactly, fields stable during stalls, ordering identical to no-stall run.
- cmd first=3,last=1 and cmd last=4 (S=5 build, last=5) -> err pulse, no out_vld, cmd_rdy back to 1.
- abort asserted at beat 5 of first=0,last=0 -> out_vld=0 next cycle, no done, next cmd starts at v=0.
- a_rst asserted mid-RUN then released -> all outputs 0 during reset, IDLE after, new cmd gives correct sequence from v=0.

Source files
------------

// File: rtl/pseudo_reverse_addr_seq.sv
// Command-driven (v, pseudo-reverse z, step) address sequencer for the permutation datapath.
// Optional output skid register: define PSEUDO_REVERSE_ADDR_SEQ_OUT_REG_EN.
module pseudo_reverse_addr_seq #(
  parameter int unsigned S = 4,
  parameter int unsigned B = 2,
  localparam int unsigned B_W = $clog2(B),
  localparam int unsigned S_W = $clog2(S),
  localparam int unsigned V_W = S * B_W
) (
  input  logic           clk,
  input  logic           a_rst,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic [S_W-1:0] cmd_step_first,
  input  logic [S_W-1:0] cmd_step_last,
  input  logic           abort,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [V_W-1:0] out_v,
  output logic [V_W-1:0] out_z,
  output logic [S_W-1:0] out_step,
  output logic           out_sol,
  output logic           out_eol,
  output logic           out_last,
  output logic           done,
  output logic           err
);

  // B is a power of two, so B^S-1 is the all-ones index.
  localparam logic [V_W-1:0] V_MAX    = '1;
  localparam logic [S_W-1:0] STEP_MAX = S_W'(S - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [V_W-1:0] v;
    logic [V_W-1:0] z;
    logic [S_W-1:0] step;
    logic           sol;
    logic           eol;
    logic           last;
  } beat_t;

  state_t         state_q, state_d;
  logic [V_W-1:0] cnt_v_q, cnt_v_d;
  logic [S_W-1:0] cnt_step_q, cnt_step_d;
  logic [S_W-1:0] last_step_q, last_step_d;
  logic           gen_done_q, gen_done_d;
  logic           err_q, err_d;
  logic           alive_q;

  logic           cmd_fire_c;
  logic           cmd_legal_c;
  logic [V_W-1:0] gen_z_c;
  beat_t          gen_beat_c;
  logic           gen_vld_c;
  logic           gen_rdy_c;
  logic           gen_fire_c;
  beat_t          head_c;
  logic           head_vld_c;
  logic           out_fire_c;

  // Command side: abort in IDLE masks acceptance; held low until first clock after reset.
  assign cmd_rdy     = (state_q == IDLE) && alive_q && !abort;
  assign cmd_fire_c  = cmd_vld && cmd_rdy;
  assign cmd_legal_c = (cmd_step_first <= cmd_step_last) && (cmd_step_last <= STEP_MAX);

  // Digits below step stay in place; the rest are taken from the top of v downward.
  always_comb begin
    gen_z_c = '0;
    for (int s = 0; s < int'(S); s++) begin
      if (s < int'(cnt_step_q)) begin
        gen_z_c[s*B_W +: B_W] = cnt_v_q[s*B_W +: B_W];
      end else begin
        gen_z_c[s*B_W +: B_W] = cnt_v_q[(int'(S) - 1 - s + int'(cnt_step_q))*B_W +: B_W];
      end
    end
  end

  always_comb begin
    gen_beat_c.v    = cnt_v_q;
    gen_beat_c.z    = gen_z_c;
    gen_beat_c.step = cnt_step_q;
    gen_beat_c.sol  = (cnt_v_q == '0);
    gen_beat_c.eol  = (cnt_v_q == V_MAX);
    gen_beat_c.last = (cnt_v_q == V_MAX) && (cnt_step_q == last_step_q);
  end

  assign gen_vld_c  = (state_q == RUN) && !gen_done_q;
  assign gen_fire_c = gen_vld_c && gen_rdy_c;
  assign out_fire_c = head_vld_c && out_rdy;

`ifdef PSEUDO_REVERSE_ADDR_SEQ_OUT_REG_EN
  logic [1:0] sk_cnt_q, sk_cnt_d;
  logic       sk_wr_q, sk_wr_d;
  logic       sk_rd_q, sk_rd_d;
  beat_t      sk_mem_q [2];
  logic       flush_c;

  // Generator only sees skid occupancy, never out_rdy directly.
  assign flush_c    = abort && (state_q == RUN);
  assign gen_rdy_c  = (sk_cnt_q != 2'd2);
  assign head_vld_c = (sk_cnt_q != 2'd0);
  assign head_c     = sk_mem_q[sk_rd_q];

  always_comb begin
    sk_cnt_d = sk_cnt_q;
    sk_wr_d  = sk_wr_q;
    sk_rd_d  = sk_rd_q;
    if (flush_c) begin
      sk_cnt_d = 2'd0;
      sk_wr_d  = 1'b0;
      sk_rd_d  = 1'b0;
    end else begin
      if (gen_fire_c) sk_wr_d = ~sk_wr_q;
      if (out_fire_c) sk_rd_d = ~sk_rd_q;
      if (gen_fire_c && !out_fire_c) begin
        sk_cnt_d = sk_cnt_q + 2'd1;
      end else if (!gen_fire_c && out_fire_c) begin
        sk_cnt_d = sk_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      sk_cnt_q <= 2'd0;
      sk_wr_q  <= 1'b0;
      sk_rd_q  <= 1'b0;
      for (int i = 0; i < 2; i++) sk_mem_q[i] <= '0;
    end else begin
      sk_cnt_q <= sk_cnt_d;
      sk_wr_q  <= sk_wr_d;
      sk_rd_q  <= sk_rd_d;
      if (gen_fire_c && !flush_c) sk_mem_q[sk_wr_q] <= gen_beat_c;
    end
  end
`else
  assign gen_rdy_c  = out_rdy;
  assign head_vld_c = gen_vld_c;
  assign head_c     = gen_beat_c;
`endif

  // Next-state: counters advance per generated beat; FSM leaves RUN when the last beat leaves the block.
  always_comb begin
    state_d     = state_q;
    cnt_v_d     = cnt_v_q;
    cnt_step_d  = cnt_step_q;
    last_step_d = last_step_q;
    gen_done_d  = gen_done_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire_c) begin
          if (cmd_legal_c) begin
            cnt_v_d     = '0;
            cnt_step_d  = cmd_step_first;
            last_step_d = cmd_step_last;
            gen_done_d  = 1'b0;
            state_d     = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (gen_fire_c) begin
            if (cnt_v_q == V_MAX) begin
              cnt_v_d = '0;
              if (cnt_step_q == last_step_q) begin
                gen_done_d = 1'b1;
              end else begin
                cnt_step_d = cnt_step_q + S_W'(1);
              end
            end else begin
              cnt_v_d = cnt_v_q + V_W'(1);
            end
          end
          if (out_fire_c && head_c.last) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= IDLE;
      cnt_v_q     <= '0;
      cnt_step_q  <= '0;
      last_step_q <= '0;
      gen_done_q  <= 1'b0;
      err_q       <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_v_q     <= cnt_v_d;
      cnt_step_q  <= cnt_step_d;
      last_step_q <= last_step_d;
      gen_done_q  <= gen_done_d;
      err_q       <= err_d;
      alive_q     <= 1'b1;
    end
  end

  // Fields read as zero whenever no beat is offered.
  assign out_vld  = head_vld_c;
  assign out_v    = head_vld_c ? head_c.v    : '0;
  assign out_z    = head_vld_c ? head_c.z    : '0;
  assign out_step = head_vld_c ? head_c.step : '0;
  assign out_sol  = head_vld_c && head_c.sol;
  assign out_eol  = head_vld_c && head_c.eol;
  assign out_last = head_vld_c && head_c.last;
  assign done     = (state_q == DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_pseudo_reverse_addr_seq.sv
// Directed + randomized bench for pseudo_reverse_addr_seq against an arithmetic reference model.
module tb_pseudo_reverse_addr_seq;

  localparam int S   = 4;
  localparam int B   = 2;
  localparam int B_W = $clog2(B);
  localparam int S_W = $clog2(S);
  localparam int V_W = S * B_W;
  localparam int NV  = B ** S;

  logic           clk = 1'b0;
  logic           a_rst;
  logic           cmd_vld;
  logic           cmd_rdy;
  logic [S_W-1:0] cmd_step_first;
  logic [S_W-1:0] cmd_step_last;
  logic           abort;
  logic           out_vld;
  logic           out_rdy;
  logic [V_W-1:0] out_v;
  logic [V_W-1:0] out_z;
  logic [S_W-1:0] out_step;
  logic           out_sol;
  logic           out_eol;
  logic           out_last;
  logic           done;
  logic           err;

  always #5 clk = ~clk;

  pseudo_reverse_addr_seq #(.S(S), .B(B)) dut (
    .clk(clk), .a_rst(a_rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_step_first(cmd_step_first), .cmd_step_last(cmd_step_last),
    .abort(abort),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_v(out_v), .out_z(out_z), .out_step(out_step),
    .out_sol(out_sol), .out_eol(out_eol), .out_last(out_last),
    .done(done), .err(err)
  );

  typedef struct {
    int v;
    int z;
    int step;
    int sol;
    int eol;
    int last;
  } beat_t;

  beat_t exp_q[$];
  int    rec_v[$];
  int    rec_z[$];
  int    rec_step[$];
  int    rec_sol[$];
  int    rec_eol[$];
  int    rec_last[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Digit d of v is (v / B^d) % B; z digit s takes v digit s below step, else v digit S-1-(s-step).
  function automatic int ref_z(input int v, input int st);
    int z;
    int src;
    z = 0;
    for (int s = 0; s < S; s++) begin
      src = (s < st) ? s : (S - 1 - (s - st));
      z += ((v / (B ** src)) % B) * (B ** s);
    end
    return z;
  endfunction

  function automatic void build_exp(input int f, input int l);
    beat_t b;
    exp_q.delete();
    for (int st = f; st <= l; st++) begin
      for (int v = 0; v < NV; v++) begin
        b.v    = v;
        b.z    = ref_z(v, st);
        b.step = st;
        b.sol  = (v == 0) ? 1 : 0;
        b.eol  = (v == NV - 1) ? 1 : 0;
        b.last = (v == NV - 1 && st == l) ? 1 : 0;
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic void clear_rec();
    rec_v.delete(); rec_z.delete(); rec_step.delete();
    rec_sol.delete(); rec_eol.delete(); rec_last.delete();
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input int f, input int l);
    int n;
    n = 0;
    cmd_step_first = S_W'(f);
    cmd_step_last  = S_W'(l);
    cmd_vld        = 1'b1;
    #1;
    while (cmd_rdy !== 1'b1 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check("cmd_rdy_wait", 32'(cmd_rdy), 32'd1);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic check_latency();
`ifdef PSEUDO_REVERSE_ADDR_SEQ_OUT_REG_EN
    check("lat_t1_vld", 32'(out_vld), 32'd0);
    @(posedge clk); #1;
    check("lat_t2_vld", 32'(out_vld), 32'd1);
`else
    check("lat_t1_vld", 32'(out_vld), 32'd1);
`endif
  endtask

  task automatic collect(input int rdy_pct, input int abort_at, output int nacc);
    int          cyc;
    bit          prev_stall;
    bit          aborting;
    logic [31:0] pv, pz, ps;
    cyc = 0; prev_stall = 1'b0; nacc = 0;
    pv = '0; pz = '0; ps = '0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      aborting = (abort_at >= 0) && (nacc == abort_at) && (out_vld === 1'b1);
      out_rdy  = aborting || (rdy_pct >= 100) || (int'($urandom_range(99)) < rdy_pct);
      abort    = aborting;
      #1;
      if (prev_stall) begin
        check("stall_vld",  32'(out_vld),  32'd1);
        check("stall_v",    32'(out_v),    pv);
        check("stall_z",    32'(out_z),    pz);
        check("stall_step", 32'(out_step), ps);
      end
      if (out_vld === 1'b1) begin
        check("beat_v",    32'(out_v),    32'(exp_q[0].v));
        check("beat_z",    32'(out_z),    32'(exp_q[0].z));
        check("beat_step", 32'(out_step), 32'(exp_q[0].step));
        check("beat_sol",  32'(out_sol),  32'(exp_q[0].sol));
        check("beat_eol",  32'(out_eol),  32'(exp_q[0].eol));
        check("beat_last", 32'(out_last), 32'(exp_q[0].last));
        check("beat_nodone", 32'(done),   32'd0);
        if (out_rdy) begin
          rec_v.push_back(int'(out_v));
          rec_z.push_back(int'(out_z));
          rec_step.push_back(int'(out_step));
          rec_sol.push_back(int'(out_sol));
          rec_eol.push_back(int'(out_eol));
          rec_last.push_back(int'(out_last));
          void'(exp_q.pop_front());
          nacc++;
        end
      end
      prev_stall = (out_vld === 1'b1) && !out_rdy;
      pv = 32'(out_v); pz = 32'(out_z); ps = 32'(out_step);
      @(posedge clk); #1;
      cyc++;
      if (aborting) begin
        abort = 1'b0;
        exp_q.delete();
      end
    end
    check("beats_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic after_done();
    check("done_pulse",    32'(done),    32'd1);
    check("done_vld_low",  32'(out_vld), 32'd0);
    @(posedge clk); #1;
    check("done_cleared",  32'(done),    32'd0);
    check("rdy_after_done", 32'(cmd_rdy), 32'd1);
  endtask

  task automatic run_legal(input int f, input int l, input int rdy_pct);
    int n;
    build_exp(f, l);
    clear_rec();
    send_cmd(f, l);
    check_latency();
    collect(rdy_pct, -1, n);
    check("beat_count", 32'(n), 32'((l - f + 1) * NV));
    after_done();
  endtask

  initial begin
    int n;
    int f;
    int l;
    a_rst = 1'b1; cmd_vld = 1'b0; abort = 1'b0; out_rdy = 1'b0;
    cmd_step_first = '0; cmd_step_last = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_out_v",   32'(out_v),   32'd0);
    check("rst_out_z",   32'(out_z),   32'd0);
    check("rst_last",    32'(out_last), 32'd0);
    a_rst = 1'b0;
    @(posedge clk); #1;
    check("idle_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("idle_out_vld", 32'(out_vld), 32'd0);

    // Single step 0: full digit reversal
    run_legal(0, 0, 100);
    if (rec_z.size() == NV) begin
      check("s0_v1_z",    32'(rec_z[1]),     32'd8);
      check("s0_v3_z",    32'(rec_z[3]),     32'd12);
      check("s0_v15_z",   32'(rec_z[15]),    32'd15);
      check("s0_v15_eol", 32'(rec_eol[15]),  32'd1);
      check("s0_v15_lst", 32'(rec_last[15]), 32'd1);
      check("s0_v14_lst", 32'(rec_last[14]), 32'd0);
    end

    // Steps 1..2
    run_legal(1, 2, 100);
    if (rec_z.size() == 2 * NV) begin
      check("s1_v2_z",   32'(rec_z[2]),     32'd8);
      check("s2_v4_z",   32'(rec_z[20]),    32'd8);
      check("s2_v6_z",   32'(rec_z[22]),    32'd10);
      check("sol_b0",    32'(rec_sol[0]),   32'd1);
      check("sol_b16",   32'(rec_sol[16]),  32'd1);
      check("sol_b1",    32'(rec_sol[1]),   32'd0);
      check("step_b16",  32'(rec_step[16]), 32'd2);
    end

    // Back-pressure: 50% out_rdy over all steps
    run_legal(0, 3, 50);

    // Illegal command: first > last
    out_rdy = 1'b1;
    send_cmd(3, 1);
    check("ill_err",     32'(err),     32'd1);
    check("ill_vld",     32'(out_vld), 32'd0);
    @(posedge clk); #1;
    check("ill_err_clr", 32'(err),     32'd0);
    check("ill_vld2",    32'(out_vld), 32'd0);
    check("ill_rdy",     32'(cmd_rdy), 32'd1);

    // Random commands with random back-pressure
    for (int k = 0; k < 4; k++) begin
      f = int'($urandom_range(S - 1));
      l = int'($urandom_range(S - 1));
      if (f <= l) begin
        run_legal(f, l, 70);
      end else begin
        send_cmd(f, l);
        check("rnd_ill_err", 32'(err),     32'd1);
        check("rnd_ill_vld", 32'(out_vld), 32'd0);
        @(posedge clk); #1;
        check("rnd_ill_rdy", 32'(cmd_rdy), 32'd1);
      end
    end

    // Abort at beat 5 of a single-step sweep
    build_exp(0, 0);
    clear_rec();
    send_cmd(0, 0);
    check_latency();
    collect(100, 5, n);
    check("abort_beats", 32'(n),       32'd6);
    check("abort_vld",   32'(out_vld), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("abort_nodone", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    check("abort_rdy", 32'(cmd_rdy), 32'd1);
    run_legal(0, 0, 100);
    if (rec_v.size() == NV) check("post_abort_v0", 32'(rec_v[0]), 32'd0);

    // Abort in IDLE wins over a pending command
    abort = 1'b1;
    cmd_vld = 1'b1; cmd_step_first = '0; cmd_step_last = '0;
    #1;
    check("idle_abort_rdy", 32'(cmd_rdy), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; cmd_vld = 1'b0;
    check("idle_abort_vld", 32'(out_vld), 32'd0);
    #1;
    check("idle_abort_rdy2", 32'(cmd_rdy), 32'd1);
    #9;

    // Reset in the middle of a sweep
    out_rdy = 1'b1;
    send_cmd(0, 3);
    repeat (10) @(posedge clk);
    #2;
    a_rst = 1'b1;
    #1;
    check("mrst_vld",  32'(out_vld),  32'd0);
    check("mrst_rdy",  32'(cmd_rdy),  32'd0);
    check("mrst_v",    32'(out_v),    32'd0);
    check("mrst_z",    32'(out_z),    32'd0);
    check("mrst_step", 32'(out_step), 32'd0);
    check("mrst_sol",  32'(out_sol),  32'd0);
    check("mrst_eol",  32'(out_eol),  32'd0);
    check("mrst_last", 32'(out_last), 32'd0);
    check("mrst_done", 32'(done),     32'd0);
    check("mrst_err",  32'(err),      32'd0);
    @(posedge clk); #3;
    a_rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_rdy_after", 32'(cmd_rdy), 32'd1);
    check("mrst_vld_after", 32'(out_vld), 32'd0);
    run_legal(0, 0, 100);
    if (rec_v.size() == NV) check("post_rst_v0", 32'(rec_v[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
